// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: one request at a time, fixed wait states, registered response.
// Optional DATA_MEM_ERR_EN macro enables misalignment / empty-lane / out-of-range error detection.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_byte_en_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_err_o
);

  localparam int unsigned NumLanes = DATA_WIDTH / 8;
  localparam int unsigned IdxW     = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NumLanes-1:0]   be_q, be_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [NumLanes-1:0]   acc_be;
  logic                  acc_err;
  logic [IdxW-1:0]       acc_idx;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic                  do_access;
  logic                  mem_we;

  // With zero wait states the access happens on the accept edge, so use the live request.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we    = req_we_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
      acc_be    = req_byte_en_i;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign acc_idx = acc_addr[IdxW+1:2];

  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < NumLanes; k++) begin
      lane_mask[8*k +: 8] = {8{acc_be[k]}};
    end
  end

`ifdef DATA_MEM_ERR_EN
  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_be == '0) ||
                   (|acc_addr[ADDR_WIDTH-1:IdxW+2]);
`else
  logic unused_acc_addr;
  assign unused_acc_addr = ^acc_addr;
  assign acc_err         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          be_d    = req_byte_en_i;
          if (WAIT_CYCLES == 0) begin
            state_d   = StResp;
            do_access = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d   = StResp;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_access) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? '0 : (mem_q[acc_idx] & lane_mask);
    end
  end

  assign mem_we = do_access && acc_we && !acc_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < NumLanes; k++) begin
        if (acc_be[k]) begin
          mem_q[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
        end
      end
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array reference model.
// Honours DATA_MEM_ERR_EN in the model the same way the design build does.
module tb_data_mem_responder;

  localparam int unsigned WaitCyc = 2;
  localparam int unsigned MemW    = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid_z, req_ready_z, req_we_z;
  logic [31:0] req_addr_z, req_wdata_z;
  logic [3:0]  req_be_z;
  logic        resp_valid_z, resp_ready_z, resp_err_z;
  logic [31:0] resp_rdata_z;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  data_mem_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(MemW), .WAIT_CYCLES(WaitCyc)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_byte_en_i(req_be),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
  );

  data_mem_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(MemW), .WAIT_CYCLES(0)
  ) u_dut_z (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_z), .req_ready_o(req_ready_z), .req_we_i(req_we_z),
    .req_addr_i(req_addr_z), .req_wdata_i(req_wdata_z), .req_byte_en_i(req_be_z),
    .resp_valid_o(resp_valid_z), .resp_ready_i(resp_ready_z),
    .resp_rdata_o(resp_rdata_z), .resp_err_o(resp_err_z)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory behaviour straight from the access rules; updates the model on stores.
  task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] erd, output logic eerr);
    int          idx;
    logic [31:0] word;
    idx = int'((addr / 4) % MemW);
`ifdef DATA_MEM_ERR_EN
    eerr = (addr % 4 != 0) || (be == 4'd0) || (addr >= 4 * MemW);
`else
    eerr = 1'b0;
`endif
    erd  = 32'd0;
    word = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
    if (!eerr) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          if (we) word[8*k +: 8] = wdata[8*k +: 8];
          else    erd[8*k +: 8]  = word[8*k +: 8];
        end
      end
      if (we) ref_mem[idx] = word;
    end
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int rdelay, input bit hold, input string tag,
                      output logic [31:0] rd_out);
    logic [31:0] erd, rd0;
    logic        eerr, e0;
    int          lat, busy_rdy;
    @(negedge clk);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    check_eq({tag, "_rdy"}, req_ready, 1);
    ref_access(we, addr, wdata, be, erd, eerr);
    @(posedge clk);
    #1;
    if (!hold) begin
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_be    = 4'($urandom);
    end
    lat      = 0;
    busy_rdy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready) busy_rdy++;
    end while (!resp_valid && lat < 40);
    check_eq({tag, "_lat"}, lat, WaitCyc + 1);
    check_eq({tag, "_busy"}, busy_rdy, 0);
    check_eq({tag, "_rdata"}, resp_rdata, erd);
    check_eq({tag, "_err"}, resp_err, eerr);
    rd0    = resp_rdata;
    e0     = resp_err;
    rd_out = resp_rdata;
    for (int i = 0; i < rdelay; i++) begin
      @(negedge clk);
      check_eq({tag, "_hold"}, {resp_valid, rd0 ^ resp_rdata, e0 ^ resp_err, req_ready},
               {1'b1, 32'd0, 1'b0, 1'b0});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, "_post"}, {req_ready, resp_valid}, 2'b10);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, rd_w0;
    logic [31:0] erd;
    logic        eerr;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    req_be       = '0;
    resp_ready   = 1'b0;
    req_valid_z  = 1'b0;
    req_we_z     = 1'b1;
    req_addr_z   = '0;
    req_wdata_z  = 32'h1;
    req_be_z     = 4'hF;
    resp_ready_z = 1'b1;

    #12;
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_valid", resp_valid, 0);
    check_eq("rst_rdata", resp_rdata, 0);
    check_eq("rst_err", resp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int w = 0; w <= 16; w++) begin
      xact(1'b1, 32'(w * 4), (w == 8) ? 32'hAABBCCDD : $urandom, 4'hF, 0, 1'b0, "pre", rd);
    end

    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, "t1st", rd);
    check_eq("t1_st_data", rd, 0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 1, 1'b0, "t1ld", rd);
    check_eq("t1_ld_data", rd, 32'hDEADBEEF);

    xact(1'b1, 32'h20, 32'h11223344, 4'b0101, 0, 1'b0, "t2st", rd);
    xact(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, "t2ldf", rd);
    check_eq("t2_full", rd, 32'hAA22CC44);
    xact(1'b0, 32'h20, 32'h0, 4'b0010, 0, 1'b0, "t2ldp", rd);
    check_eq("t2_part", rd, 32'h0000CC00);

    xact(1'b0, 32'h20, 32'h0, 4'hF, 5, 1'b1, "t3", rd);
    check_eq("t3_data", rd, 32'hAA22CC44);

    xact(1'b1, 32'h12, 32'h55555555, 4'hF, 0, 1'b0, "t4st", rd);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, "t4ld", rd);
`ifdef DATA_MEM_ERR_EN
    check_eq("t4_unchanged", rd, 32'hDEADBEEF);
`endif
    xact(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, "t4w0", rd_w0);
    xact(1'b0, 32'(4 * MemW), 32'h0, 4'hF, 0, 1'b0, "t4oor", rd);
`ifdef DATA_MEM_ERR_EN
    check_eq("t4_oor_data", rd, 0);
`else
    check_eq("t4_wrap_data", rd, rd_w0);
`endif

    // Store is dropped by a reset arriving during its wait states.
    @(negedge clk);
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'hCAFEF00D;
    req_be    = 4'hF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_eq("t5_valid", resp_valid, 0);
    check_eq("t5_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    ref_access(1'b0, 32'h40, 32'h0, 4'hF, erd, eerr);
    xact(1'b0, 32'h40, 32'h0, 4'hF, 0, 1'b0, "t5ld", rd);
    check_eq("t5_prior", rd, erd);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 16) * 4);
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) a = a + 32'(4 * MemW);
      xact(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), 1'b0, "rnd",
           rd);
    end

    // Zero-wait instance: accept every second cycle with both sides always ready.
    @(negedge clk);
    req_valid_z = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check_eq("t6_ready", req_ready_z, (k % 2) == 0);
      check_eq("t6_valid", resp_valid_z, (k % 2) == 1);
      if (resp_valid_z) check_eq("t6_err", resp_err_z, 0);
      @(negedge clk);
    end
    req_valid_z = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
